// File: rtl/wallace_tree_pipe.sv
// wallace_tree_pipe
//   Pipelined Wallace-tree reducer: compresses NUM_PP partial products of
//   WIDTH bits into one redundant sum/carry pair. It uses LEVELS =
//   log2(NUM_PP)-1 levels of 4:2 compressor rows, with one register stage
//   per level. Both sides use valid/ready handshakes, and a synchronous
//   flush kills every in-flight entry.
//
//   The guaranteed property is
//     (sum_out + carry_out) mod 2^WIDTH == (sum of PPs) mod 2^WIDTH.
//   Carries out of bit WIDTH-1 are dropped at every level.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   flush      in   synchronous kill of all in-flight entries
//   in_valid   in   pp_in is valid
//   in_ready   out  block accepts pp_in this cycle
//   pp_in      in   NUM_PP*WIDTH; PP k at [k*WIDTH +: WIDTH], pre-aligned
//   out_valid  out  sum_out/carry_out are valid
//   out_ready  in   downstream accepts the result
//   sum_out    out  WIDTH redundant sum vector
//   carry_out  out  WIDTH redundant carry vector, already aligned
module wallace_tree_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_PP = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PP*WIDTH-1:0] pp_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        sum_out,
  output logic [WIDTH-1:0]        carry_out
);

  localparam int LEVELS = $clog2(NUM_PP) - 1;
  // Total registered vectors over all levels: NUM_PP/2 + NUM_PP/4 + ... + 2.
  localparam int NREG   = NUM_PP - 2;

  if (!(NUM_PP == 4 || NUM_PP == 8 || NUM_PP == 16)) begin : g_bad_num_pp
    $error("wallace_tree_pipe: NUM_PP must be 4, 8 or 16 (got %0d)", NUM_PP);
  end
  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("wallace_tree_pipe: WIDTH must be in 8..64 (got %0d)", WIDTH);
  end

  // One row of 4:2 compressors with a ripple Cin/Cout chain (Cin[0] = 0).
  // Result packing is {sum, carry}, and the carry is already shifted left by
  // one, with its MSB carry dropped.
  function automatic logic [2*WIDTH-1:0] comp42(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cy;
    logic             ci;
    logic             s1;
    logic             co;
    s  = '0;
    cy = '0;
    ci = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s1    = a[i] ^ b[i] ^ c[i];
      co    = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      s[i]  = s1 ^ d[i] ^ ci;
      cy[i] = (s1 & d[i]) | (s1 & ci) | (d[i] & ci);
      ci    = co;
    end
    return {s, cy[WIDTH-2:0], 1'b0};
  endfunction

  // All stage registers live in one flat array. Level l owns entries
  // [NUM_PP - (NUM_PP>>l), NUM_PP - (NUM_PP>>(l+1))), so the last level
  // holds the two output vectors at NREG-2 and NREG-1.
  logic [WIDTH-1:0]  stage_q [NREG];
  logic [WIDTH-1:0]  red     [NREG];
  logic [NREG-1:0]   entry_load;

  logic [LEVELS-1:0] stage_valid;
  logic [LEVELS-1:0] advance;
  logic [LEVELS-1:0] load;
  logic [LEVELS:0]   valid_in;

  assign valid_in = {stage_valid, in_valid};

  // A stage advances when it or any stage ahead of it is empty, or when
  // out_ready is high. This is the unrolled form of the recursive rule, and
  // it avoids a combinational self-reference.
  always_comb begin
    advance = '0;
    for (int unsigned i = 0; i < LEVELS; i++) begin
      advance[i] = out_ready;
      for (int unsigned j = i; j < LEVELS; j++) begin
        if (!stage_valid[j]) advance[i] = 1'b1;
      end
    end
  end

  assign load = advance & valid_in[LEVELS-1:0] & {LEVELS{~flush}};

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN    = NUM_PP >> l;
    localparam int OFF_OUT = NUM_PP - N_IN;
    localparam int OFF_IN  = NUM_PP - 2 * N_IN;

    for (genvar g = 0; g < N_IN / 4; g++) begin : g_row
      logic [WIDTH-1:0]   a, b, c, d;
      logic [2*WIDTH-1:0] pair;
      if (l == 0) begin : g_src
        assign a = pp_in[(4*g+0)*WIDTH +: WIDTH];
        assign b = pp_in[(4*g+1)*WIDTH +: WIDTH];
        assign c = pp_in[(4*g+2)*WIDTH +: WIDTH];
        assign d = pp_in[(4*g+3)*WIDTH +: WIDTH];
      end else begin : g_src
        assign a = stage_q[OFF_IN + 4*g + 0];
        assign b = stage_q[OFF_IN + 4*g + 1];
        assign c = stage_q[OFF_IN + 4*g + 2];
        assign d = stage_q[OFF_IN + 4*g + 3];
      end
      assign pair                 = comp42(a, b, c, d);
      assign red[OFF_OUT + 2*g]   = pair[2*WIDTH-1:WIDTH];
      assign red[OFF_OUT + 2*g+1] = pair[WIDTH-1:0];
    end

    for (genvar k = 0; k < N_IN / 2; k++) begin : g_en
      assign entry_load[OFF_OUT + k] = load[l];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int unsigned k = 0; k < NREG; k++) stage_q[k] <= '0;
    end else begin
      if (flush) begin
        stage_valid <= '0;
      end else begin
        for (int unsigned i = 0; i < LEVELS; i++) begin
          if (advance[i]) stage_valid[i] <= valid_in[i];
        end
      end
      for (int unsigned k = 0; k < NREG; k++) begin
        if (entry_load[k]) stage_q[k] <= red[k];
      end
    end
  end

  assign in_ready  = rst_n & advance[0];
  assign out_valid = stage_valid[LEVELS-1];
  assign sum_out   = stage_q[NREG-2];
  assign carry_out = stage_q[NREG-1];

endmodule

// File: tb/tb_wallace_tree_pipe.sv
// Bench for wallace_tree_pipe. One default-configuration DUT (32x8) gets
// directed vectors. Six more instances cover NUM_PP 4/8/16 at WIDTH 16/64
// under random traffic. Each instance has a queue-based reference: results
// must equal the plain PP sum mod 2^WIDTH, in order. out_valid is expected
// once the oldest item has been in flight for LEVELS cycles. in_ready is
// expected while fewer than LEVELS items are held, or out_ready is high.
module tb_wallace_tree_pipe;

  localparam int W  = 32;
  localparam int NP = 8;
  localparam int LV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_done = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] s;
    int unsigned t;
  } ent_t;

  // ---------------- main DUT: WIDTH=32, NUM_PP=8 ----------------
  logic              rst_n, flush, in_valid, out_ready;
  logic [NP*W-1:0]   pp_in;
  logic              in_ready, out_valid;
  logic [W-1:0]      sum_out, carry_out;

  wallace_tree_pipe #(.WIDTH(W), .NUM_PP(NP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .pp_in(pp_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum_out(sum_out), .carry_out(carry_out)
  );

  function automatic logic [W-1:0] ref_sum(input logic [NP*W-1:0] v);
    logic [W-1:0] acc = '0;
    for (int k = 0; k < NP; k++) acc = acc + v[k*W +: W];
    return acc;
  endfunction

  ent_t         q[$];
  int unsigned  n_out = 0;
  logic         m_rdy, m_ov;
  logic [W-1:0] m_tot;

  always @(negedge clk) begin
    m_rdy = rst_n && ((q.size() < LV) || out_ready);
    m_ov  = (q.size() > 0) && (cyc >= q[0].t + LV);
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov && out_valid) begin
      m_tot = sum_out + carry_out;
      chk("contract", m_tot, q[0].s);
    end
    if (!rst_n) q.delete();
    else begin
      if (m_ov && out_ready) begin
        void'(q.pop_front());
        n_out++;
      end
      if (flush) q.delete();
      else if (in_valid && m_rdy) q.push_back('{64'(ref_sum(pp_in)), cyc});
    end
  end

  task automatic rand_pp(output logic [NP*W-1:0] v);
    for (int j = 0; j < NP; j++) v[j*W +: W] = $urandom();
  endtask

  // Present v until accepted; hs returns the handshake cycle.
  task automatic send(input logic [NP*W-1:0] v, output int unsigned hs);
    bit ok = 1'b0;
    hs       = 0;
    pp_in    = v;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      hs = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", ok, 1'b1);
  endtask

  initial begin
    logic [NP*W-1:0] v;
    logic [W-1:0]    tot;
    int unsigned     hs, n0;
    int              cnt;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum_out, 32'h0);
    chk("rst_carry", carry_out, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Single item 1..8: out_valid exactly two cycles after acceptance, sum 36.
    for (int k = 0; k < NP; k++) v[k*W +: W] = W'(k + 1);
    send(v, hs);
    @(negedge clk);
    chk("single_not_early", out_valid, 1'b0);
    @(negedge clk);
    chk("single_latency", out_valid, 1'b1);
    tot = sum_out + carry_out;
    chk("single_sum36", tot, 32'd36);
    repeat (2) @(posedge clk);
    #1;

    // Wrap-around: eight 0xFFFFFFFF -> 0xFFFFFFF8.
    v = '1;
    send(v, hs);
    @(negedge clk);
    @(negedge clk);
    chk("wrap_valid", out_valid, 1'b1);
    tot = sum_out + carry_out;
    chk("wrap_sum", tot, 32'hFFFF_FFF8);
    repeat (2) @(posedge clk);
    #1;

    // Streaming 100 back-to-back items with out_ready held high.
    n0 = n_out; cnt = 0; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_pp(v); pp_in = v;
      @(negedge clk);
      if (!in_ready) cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stream_ready_drops", cnt, 0);
    chk("stream_count", n_out - n0, 100);

    // Backpressure: out_ready low for five cycles while streaming.
    n0 = n_out; cnt = 0; out_ready = 1'b0; in_valid = 1'b1;
    rand_pp(v); pp_in = v;
    for (int i = 0; i < 5; i++) begin
      bit acc;
      @(negedge clk);
      acc = in_ready;
      if (acc) cnt++;
      @(posedge clk); #1;
      if (acc) begin rand_pp(v); pp_in = v; end
    end
    chk("bp_accepted", cnt, 2);
    @(negedge clk);
    chk("bp_ready_low", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit acc;
      @(negedge clk);
      acc = in_ready;
      if (acc) cnt++;
      @(posedge clk); #1;
      if (acc) begin rand_pp(v); pp_in = v; end
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_count", n_out - n0, cnt);

    // Flush with two items in flight and a third presented in the flush cycle.
    n0 = n_out; in_valid = 1'b1;
    rand_pp(v); pp_in = v;
    @(posedge clk); #1 rand_pp(v); pp_in = v;
    @(posedge clk); #1 rand_pp(v); pp_in = v; out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("flush_none_out", n_out - n0, 0);
    @(posedge clk); #1;

    // Flush while in_ready is high: the flush-cycle input is dropped too.
    n0 = n_out; in_valid = 1'b1;
    rand_pp(v); pp_in = v;
    @(posedge clk); #1 rand_pp(v); pp_in = v; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_high", in_ready, 1'b1);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush2_out_valid", out_valid, 1'b0);
    repeat (5) @(negedge clk);
    chk("flush2_none_out", n_out - n0, 0);
    @(posedge clk); #1;

    // Mid-stream reset while stalled with held items.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_pp(v); pp_in = v;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_full_valid", out_valid, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum_out, 32'h0);
    chk("mid_rst_carry", carry_out, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;

    begin
      bit all_done = 1'b0;
      for (int i = 0; i < 4000 && !all_done; i++) begin
        @(posedge clk);
        all_done = (n_done == 6);
      end
      chk("sweep_done", all_done, 1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- parameter sweep: NUM_PP 4/8/16 x WIDTH 16/64 ----------------
  for (genvar c = 0; c < 6; c++) begin : g_sw
    localparam int SW      = (c < 3) ? 16 : 64;
    localparam int SNP     = (c % 3 == 0) ? 4 : ((c % 3 == 1) ? 8 : 16);
    localparam int SLV     = $clog2(SNP) - 1;
    localparam int EXP_LAT = (SNP == 4) ? 1 : ((SNP == 8) ? 2 : 3);

    logic              s_rst_n, s_flush, s_in_valid, s_out_ready;
    logic [SNP*SW-1:0] s_pp;
    logic              s_in_ready, s_out_valid;
    logic [SW-1:0]     s_sum, s_carry;

    wallace_tree_pipe #(.WIDTH(SW), .NUM_PP(SNP)) dut_sw (
      .clk(clk), .rst_n(s_rst_n), .flush(s_flush), .in_valid(s_in_valid),
      .in_ready(s_in_ready), .pp_in(s_pp), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .sum_out(s_sum), .carry_out(s_carry)
    );

    function automatic logic [SW-1:0] s_ref(input logic [SNP*SW-1:0] v);
      logic [SW-1:0] acc = '0;
      for (int k = 0; k < SNP; k++) acc = acc + v[k*SW +: SW];
      return acc;
    endfunction

    ent_t          sq[$];
    logic          e_rdy, e_ov;
    logic [SW-1:0] e_tot;

    always @(negedge clk) begin
      e_rdy = s_rst_n && ((sq.size() < SLV) || s_out_ready);
      e_ov  = (sq.size() > 0) && (cyc >= sq[0].t + SLV);
      chk("sw_in_ready", s_in_ready, e_rdy);
      chk("sw_out_valid", s_out_valid, e_ov);
      if (e_ov && s_out_valid) begin
        e_tot = s_sum + s_carry;
        chk("sw_contract", e_tot, sq[0].s);
      end
      if (!s_rst_n) sq.delete();
      else begin
        if (e_ov && s_out_ready) void'(sq.pop_front());
        if (s_flush) sq.delete();
        else if (s_in_valid && e_rdy) sq.push_back('{64'(s_ref(s_pp)), cyc});
      end
    end

    task automatic s_rand();
      for (int j = 0; j < SNP * SW / 32; j++) s_pp[j*32 +: 32] = $urandom();
    endtask

    initial begin
      int unsigned hs;
      int          lat;
      bit          hs_ok;
      s_rst_n = 1'b0; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_pp = '0;
      repeat (2) @(posedge clk);
      #1 s_rst_n = 1'b1;

      // Latency probe on an empty pipe.
      s_rand(); s_in_valid = 1'b1;
      @(negedge clk);
      hs_ok = s_in_ready; hs = cyc;
      @(posedge clk); #1 s_in_valid = 1'b0;
      chk("sw_probe_accept", hs_ok, 1'b1);
      lat = 0;
      for (int i = 0; i < 8 && lat == 0; i++) begin
        @(negedge clk);
        if (s_out_valid) lat = int'(cyc - hs);
      end
      chk("sw_latency", lat, EXP_LAT);
      @(posedge clk); #1;

      // Random traffic with occasional flush.
      for (int i = 0; i < 150; i++) begin
        s_rand();
        s_in_valid  = ($urandom_range(0, 3) != 0);
        s_out_ready = ($urandom_range(0, 3) != 0);
        s_flush     = ($urandom_range(0, 39) == 0);
        @(posedge clk); #1;
      end
      s_flush = 1'b0;

      // Fill while stalled, then reset mid-stream.
      s_in_valid = 1'b1; s_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        s_rand();
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("sw_full_before_rst", s_out_valid, 1'b1);
      @(posedge clk); #1 s_rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("sw_rst_out_valid", s_out_valid, 1'b0);
      chk("sw_rst_sum", s_sum, 64'h0);
      chk("sw_rst_carry", s_carry, 64'h0);
      @(posedge clk); #1 s_rst_n = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b1;
      repeat (4) @(posedge clk);
      n_done++;
    end
  end

endmodule

// File: doc/wallace_tree_pipe.md
# wallace_tree_pipe

Parametrised, pipelined Wallace-tree partial-product reducer for the multiplier datapath. It compresses NUM_PP partial products of WIDTH bits into one redundant sum/carry pair using levels of 4:2 compressors, with one register stage per level. It has valid/ready handshakes on both sides and a synchronous flush. It sits between the partial-product generator and the final carry-propagate adder, and replaces the fixed 8x32 combinational reducer in the pipelined multiplier.

## Interface
Parameters:
- WIDTH, 32, bit width of each partial product and of both outputs; legal range 8..64.
- NUM_PP, 8, number of partial products; legal values 4, 8, 16. Any other value is an elaboration error.
- LEVELS, derived as log2(NUM_PP)-1, number of 4:2 levels and register stages. It is not user-settable.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  the pp_in vector is valid.
- in_ready  out  1  the block accepts pp_in this cycle.
- pp_in  in  NUM_PP*WIDTH  partial products; PP k occupies bits [k*WIDTH +: WIDTH]. Each PP arrives already shifted and aligned.
- out_valid  out  1  sum_out and carry_out are valid.
- out_ready  in  1  the downstream stage accepts the result.
- sum_out  out  WIDTH  redundant sum vector.
- carry_out  out  WIDTH  redundant carry vector, already aligned (no further shift).

## Operation
- Arithmetic contract: (sum_out + carry_out) mod 2^WIDTH equals (sum of all NUM_PP PPs) mod 2^WIDTH.
  - Carries out of bit WIDTH-1 are discarded at every level.
  - The split between sum_out and carry_out is implementation-defined. Benches check only the contract.
- Reduction structure:
  - Level L groups its operands in fours and reduces each group to two with a row of 4:2 compressors.
  - Each row uses its own Cin/Cout chain. Cin at bit 0 is 0.
  - Each carry bit moves left by one position. The carry out of the MSB is dropped.
  - Level L takes NUM_PP/2^L operands and produces NUM_PP/2^(L+1) operands.
  - The final level produces exactly two vectors.
- Pipeline:
  - Each level has its own registered data and a stage_valid bit.
  - Stage i advances when it is empty, or when stage i+1 advances. For the last stage, "stage i+1 advances" means out_ready is high.
  - in_ready = !stage0_valid || stage0 advances. This path is combinational, so the pipe accepts one item per cycle at full throughput.
  - A transfer into the block happens when in_valid && in_ready. A transfer out happens when out_valid && out_ready.
  - Data registers load only when their stage advances with valid data.
- Stall: if out_ready is low while out_valid is high, sum_out and carry_out hold steady. Upstream stages keep filling until every stage is occupied, and then in_ready drops.
- Flush:
  - All stage_valid bits clear on the next edge.
  - An input presented in the same cycle as flush is dropped, even if in_ready was high.
  - Data registers do not need to clear.

## Timing
- Reset (rst_n low at an edge):
  - All stage_valid bits clear to 0, so out_valid = 0.
  - sum_out and carry_out reset to 0.
  - in_ready is forced to 0 while rst_n is low, and is 1 in the first cycle after release.
- Latency:
  - Without backpressure, an input accepted at edge N appears with out_valid high after edge N+LEVELS.
  - With the default NUM_PP=8 this is 2 cycles. NUM_PP=4 gives 1 cycle; NUM_PP=16 gives 3 cycles.
- Throughput: one result per cycle while out_ready stays high.
- Capacity: the block holds LEVELS items. Once full with out_ready low, in_ready is 0.
- Simultaneous full and drain: if the pipe is full and out_ready is high, in_ready is 1 in the same cycle. There is no bubble.
- Priority: rst_n > flush > normal advance.
- Reset or flush while stalled: the held items are discarded, and out_valid falls after that edge.

## Test plan
- Single item (WIDTH=32, NUM_PP=8): PPs 1,2,3,4,5,6,7,8 -> out_valid high exactly 2 cycles after acceptance, and sum_out+carry_out = 36.
- Wrap-around: all eight PPs = 0xFFFFFFFF -> (sum_out+carry_out) mod 2^32 = 0xFFFFFFF8.
- Streaming: 100 back-to-back random vectors with out_ready held at 1 -> in_ready stays 1 throughout, 100 results come out in order, and each matches the reference sum mod 2^32.
- Backpressure: hold out_ready at 0 for 5 cycles while streaming -> in_ready falls after 2 items are accepted, outputs hold steady, and no item is lost or duplicated after release.
- Flush: assert flush with 2 items in flight plus a valid input in the same cycle -> out_valid is 0 on the next cycle, and none of those 3 items ever appear at the output.
- Parameter sweep: run NUM_PP = 4, 8, 16 with WIDTH = 16 and 64 under random traffic -> latency is 1, 2, 3 cycles respectively, and every result satisfies the contract. After mid-stream reset, out_valid, sum_out and carry_out are all 0.
